aes_inv_key_expansion: RTL and testbench
========================================

Name: aes_inv_key_expansion

Overview:
- Reverse-order AES-128 key schedule generator for the decryption datapath.
- Takes the final round key (round LAST_ROUND) and produces round keys LAST_ROUND, LAST_ROUND-1, …, 0, one per handshake.
- Uses the inverse key-schedule recurrence, so no 11-entry key store is needed.
- Sits between the key register and the inverse-cipher round unit, which consumes keys over a valid/ready handshake.

Parameters:
- LAST_ROUND, default 10: index of the round key applied at load; legal range 1..10.

Ports:
- clk, input, 1: system clock; all logic rising-edge.
- rst_n, input, 1: synchronous active-low reset.
- start, input, 1: load request; honoured only in IDLE.
- last_key, input, [0:127]: round-LAST_ROUND key; bit 0 is the MSB of word 0; sampled on an accepted start.
- key_ready, input, 1: consumer accepts round_key this cycle.
- round_key, output, [0:127]: current round key; words w0=[0:31], w1=[32:63], w2=[64:95], w3=[96:127].
- round_num, output, [3:0]: round index of round_key.
- key_valid, output, 1: round_key/round_num valid.
- busy, output, 1: high in RUN.
- done, output, 1: one-cycle pulse after round-0 key is accepted.

Behaviour:
- Reset (rst_n=0 at a clk edge), from any state including mid-sequence:
  - state goes to IDLE.
  - round_key=0, round_num=0, key_valid=0, busy=0, done=0.
  - No partial sequence resumes.
- FSM states: IDLE, RUN.
- IDLE:
  - key_valid=0.
  - start=1 → next cycle: round_key=last_key, round_num=LAST_ROUND, key_valid=1, busy=1, state RUN.
  - Load latency is 1 cycle.
- RUN, handshake:
  - Transfer = key_valid & key_ready.
  - Without a transfer, round_key and round_num hold stable. No valid deassertion once asserted.
- RUN, transfer with round_num=r>0, computed from the current words k0..k3:
  - p3=k3^k2, p2=k2^k1, p1=k1^k0.
  - p0=k0^SubWord(RotWord(p3))^Rcon(r).
  - RotWord takes bytes [b0,b1,b2,b3] to [b1,b2,b3,b0].
  - SubWord is the forward AES S-box per byte (not the inverse S-box).
  - Rcon(r) MSByte by round: r=1..8: 01, 02, 04, 08, 10, 20, 40, 80; r=9: 1B; r=10: 36. Lower three bytes are 0.
  - Next cycle: round_key={p0,p1,p2,p3}, round_num=r-1, key_valid stays 1.
  - One new key per cycle when key_ready is held high.
- RUN, transfer with round_num=0:
  - Next cycle: key_valid=0, busy=0, done=1 for exactly one cycle, state IDLE.
  - round_key and round_num hold their last values.
- start outside IDLE is ignored, including in the final-transfer cycle. start in the done cycle is accepted (state is already IDLE).
- last_key changes outside an accepted start have no effect.
- Total sequence: LAST_ROUND+1 keys; minimum LAST_ROUND+2 cycles from start to done.
- S-box is a combinational ROM on p3; the recurrence is single-cycle. No multicycle paths.

Test Plan:
1. FIPS-197 A.1, key_ready=1: start with last_key=d014f9a8c9ee2589e13f0cc8b6630ca6 → 1 cycle later round_num=10, that key. Next cycle round_num=9, ac7766f319fadc2128d12941575c006e. Round 1 = a0fafe1788542cb123a339392a6c7605. Round 0 = 2b7e151628aed2a6abf7158809cf4f3c. done pulses 12 cycles after start.
2. Backpressure: same vector, key_ready toggled pseudo-randomly → identical 11-key sequence. round_key/round_num stable while key_valid=1 and key_ready=0; no key skipped or duplicated.
3. Ignored start: assert start with a different last_key at round_num=5 and in the round-0 transfer cycle → sequence unaffected. Then start in the done cycle → new sequence begins with round 10 one cycle later.
4. Reset mid-operation: rst_n=0 for one edge at round_num=6 → next cycle all outputs 0 and IDLE. A subsequent start reproduces the scenario 1 sequence from round 10.
5. Scoreboard: 200 random 128-bit keys expanded by a reference model; feed each round-10 key → every emitted round key matches the model, including all-zero and all-FF keys.
6. Parameter LAST_ROUND=1, last_key=a0fafe1788542cb123a339392a6c7605 → emits round 1 then round 0 (2b7e1516…4f3c). done pulses 3 cycles after start.

Source files
------------

// File: rtl/aes_inv_key_expansion_if.sv
// Handshake bundle between the key register/consumer side and the inverse key expansion unit.
// The expansion unit uses the slave modport; the controlling side uses master.
interface aes_inv_key_expansion_if;
  logic           start;
  logic [0:127]   last_key;
  logic           key_ready;
  logic [0:127]   round_key;
  logic [3:0]     round_num;
  logic           key_valid;
  logic           busy;
  logic           done;

  modport master (
    output start,
    output last_key,
    output key_ready,
    input  round_key,
    input  round_num,
    input  key_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  last_key,
    input  key_ready,
    output round_key,
    output round_num,
    output key_valid,
    output busy,
    output done
  );
endinterface

// File: rtl/aes_inv_key_expansion.sv
// Reverse-order AES-128 key schedule: loads the last round key and walks back to round 0,
// one key per valid/ready transfer, using the inverse recurrence instead of a key store.
module aes_inv_key_expansion #(
  parameter int unsigned LAST_ROUND = 10
) (
  input logic                   clk,
  input logic                   rst_n,
  aes_inv_key_expansion_if.slave bus
);

  // Forward AES S-box, byte i at bits [8*i +: 8].
  localparam logic [0:2047] SboxTable = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SboxTable[8*int'(b) +: 8];
  endfunction

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e       state_q, state_d;
  logic [0:127] key_q, key_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         done_q, done_d;

  logic [31:0]  k0, k1, k2, k3;
  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  rot;
  logic [7:0]   rcon;
  logic         xfer;

  assign k0 = key_q[0:31];
  assign k1 = key_q[32:63];
  assign k2 = key_q[64:95];
  assign k3 = key_q[96:127];

  // Undo the forward recurrence: w[i-4] = w[i] ^ w[i-1], with the g() term on word 0.
  assign p3  = k3 ^ k2;
  assign p2  = k2 ^ k1;
  assign p1  = k1 ^ k0;
  assign rot = {p3[23:0], p3[31:24]};
  assign p0  = k0 ^ {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                  ^ {rcon, 24'h0};

  always_comb begin
    rcon = 8'h00;
    case (rnd_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign xfer = (state_q == StRun) && bus.key_ready;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          key_d   = bus.last_key;
          rnd_d   = 4'(LAST_ROUND);
        end
      end
      StRun: begin
        if (xfer) begin
          if (rnd_q == 4'd0) begin
            // Key and round number stay on the bus after the final transfer.
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            key_d = {p0, p1, p2, p3};
            rnd_d = rnd_q - 4'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      key_q   <= '0;
      rnd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
    end
  end

  assign bus.round_key = key_q;
  assign bus.round_num = rnd_q;
  assign bus.key_valid = (state_q == StRun);
  assign bus.busy      = (state_q == StRun);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_aes_inv_key_expansion.sv
// Directed and model-based bench for the reverse AES-128 key schedule; the reference model
// runs the forward expansion with an S-box derived from GF(2^8) inversion.
module tb_aes_inv_key_expansion;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_inv_key_expansion_if ifa ();
  aes_inv_key_expansion_if ifb ();

  aes_inv_key_expansion #(.LAST_ROUND(10)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  aes_inv_key_expansion #(.LAST_ROUND(1))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  localparam logic [127:0] FipsR0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FipsR1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FipsR9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FipsR10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sbox_m   [256];
  logic [127:0] exp_keys [11];
  logic [127:0] got_key  [16];
  int           got_rnd  [16];
  int           got_n;
  int           done_at;
  int           unstable;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] xb, inv, s;
    for (int x = 0; x < 256; x++) begin
      xb  = x[7:0];
      inv = 8'h00;
      if (xb != 8'h00)
        for (int y = 1; y < 256; y++)
          if (gmul(xb, y[7:0]) == 8'h01) inv = y[7:0];
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_m[x] = s;
    end
  endtask

  task automatic expand(input logic [127:0] key0);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    w[0] = key0[127:96];
    w[1] = key0[95:64];
    w[2] = key0[63:32];
    w[3] = key0[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Drives one sequence on dut_a and records every transferred key; stops at done or budget.
  task automatic run_seq(input logic [127:0] k10, input bit rnd_ready, input bit poke);
    logic         held;
    logic [127:0] pk;
    logic [3:0]   pr;
    int           c;
    got_n = 0; done_at = -1; unstable = 0; held = 1'b0; pk = '0; pr = '0;
    ifa.last_key = k10; ifa.start = 1'b1; ifa.key_ready = 1'b1;
    tick();
    ifa.start = 1'b0;
    c = 1;
    while (c <= 300 && done_at < 0) begin
      if (ifa.done) begin
        done_at = c;
      end else begin
        if (held && (ifa.round_key !== pk || ifa.round_num !== pr || ifa.key_valid !== 1'b1))
          unstable++;
        ifa.key_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        ifa.start = poke && ifa.key_valid && (ifa.round_num == 4'd5 || ifa.round_num == 4'd0);
        if (poke) ifa.last_key = ~k10;
        if (ifa.key_valid && ifa.key_ready && got_n < 16) begin
          got_key[got_n] = ifa.round_key;
          got_rnd[got_n] = int'(ifa.round_num);
          got_n++;
        end
        held = ifa.key_valid && !ifa.key_ready;
        pk = ifa.round_key;
        pr = ifa.round_num;
        tick();
        c++;
      end
    end
    ifa.start = 1'b0;
    ifa.key_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (ifa.round_key !== '0 || ifa.round_num !== 4'd0 || ifa.key_valid !== 1'b0 ||
        ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got key=%h rnd=%0d v=%b b=%b d=%b want all zero",
               ifa.round_key, ifa.round_num, ifa.key_valid, ifa.busy, ifa.done);
    end
  endtask

  task automatic test_fips();
    expand(FipsR0);
    run_seq(FipsR10, 1'b0, 1'b0);
    n_checks++;
    if (done_at !== 12) begin
      n_fail++; $display("FAIL fips_done_latency: got %0d want 12", done_at);
    end
    n_checks++;
    if (got_n !== 11) begin
      n_fail++; $display("FAIL fips_key_count: got %0d want 11", got_n);
    end
    for (int i = 0; i < 11; i++) begin
      n_checks++;
      if (got_key[i] !== exp_keys[10-i] || got_rnd[i] !== 10 - i) begin
        n_fail++;
        $display("FAIL fips_key[%0d]: got rnd=%0d %h want rnd=%0d %h",
                 i, got_rnd[i], got_key[i], 10 - i, exp_keys[10-i]);
      end
    end
    n_checks++;
    if (got_key[0] !== FipsR10 || got_key[1] !== FipsR9 || got_key[9] !== FipsR1 ||
        got_key[10] !== FipsR0) begin
      n_fail++;
      $display("FAIL fips_vectors: got r10=%h r9=%h r1=%h r0=%h", got_key[0], got_key[1],
               got_key[9], got_key[10]);
    end
    n_checks++;
    if (ifa.key_valid !== 1'b0 || ifa.busy !== 1'b0 || ifa.round_num !== 4'd0 ||
        ifa.round_key !== FipsR0) begin
      n_fail++;
      $display("FAIL fips_done_cycle: got v=%b b=%b rnd=%0d key=%h want 0 0 0 %h",
               ifa.key_valid, ifa.busy, ifa.round_num, ifa.round_key, FipsR0);
    end
    tick();
    n_checks++;
    if (ifa.done !== 1'b0) begin
      n_fail++; $display("FAIL fips_done_pulse_width: got done=%b want 0", ifa.done);
    end
  endtask

  task automatic test_backpressure();
    expand(FipsR0);
    run_seq(FipsR10, 1'b1, 1'b0);
    n_checks++;
    if (done_at < 0 || got_n !== 11) begin
      n_fail++; $display("FAIL bp_completion: got done_at=%0d keys=%0d want done, 11", done_at, got_n);
    end
    n_checks++;
    if (unstable !== 0) begin
      n_fail++; $display("FAIL bp_stability: got %0d changes while stalled want 0", unstable);
    end
    for (int i = 0; i < 11; i++) begin
      n_checks++;
      if (got_key[i] !== exp_keys[10-i] || got_rnd[i] !== 10 - i) begin
        n_fail++;
        $display("FAIL bp_key[%0d]: got rnd=%0d %h want rnd=%0d %h",
                 i, got_rnd[i], got_key[i], 10 - i, exp_keys[10-i]);
      end
    end
  endtask

  task automatic test_ignored_start();
    logic [127:0] k2;
    expand(FipsR0);
    run_seq(FipsR10, 1'b0, 1'b1);
    n_checks++;
    if (done_at !== 12 || got_n !== 11) begin
      n_fail++; $display("FAIL ign_timing: got done_at=%0d keys=%0d want 12, 11", done_at, got_n);
    end
    for (int i = 0; i < 11; i++) begin
      n_checks++;
      if (got_key[i] !== exp_keys[10-i] || got_rnd[i] !== 10 - i) begin
        n_fail++;
        $display("FAIL ign_key[%0d]: got rnd=%0d %h want rnd=%0d %h",
                 i, got_rnd[i], got_key[i], 10 - i, exp_keys[10-i]);
      end
    end
    k2 = 128'h00112233445566778899aabbccddeeff;
    ifa.last_key = k2;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    n_checks++;
    if (ifa.key_valid !== 1'b1 || ifa.round_num !== 4'd10 || ifa.round_key !== k2) begin
      n_fail++;
      $display("FAIL start_in_done_cycle: got v=%b rnd=%0d key=%h want 1 10 %h",
               ifa.key_valid, ifa.round_num, ifa.round_key, k2);
    end
    apply_reset();
  endtask

  task automatic test_reset_mid();
    int waited;
    expand(FipsR0);
    ifa.last_key = FipsR10; ifa.start = 1'b1; ifa.key_ready = 1'b1;
    tick();
    ifa.start = 1'b0;
    waited = 0;
    while (ifa.round_num !== 4'd6 && waited < 20) begin
      tick();
      waited++;
    end
    n_checks++;
    if (ifa.round_num !== 4'd6) begin
      n_fail++; $display("FAIL rst_mid_reach6: got rnd=%0d want 6", ifa.round_num);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ifa.key_ready = 1'b0;
    n_checks++;
    if (ifa.round_key !== '0 || ifa.round_num !== 4'd0 || ifa.key_valid !== 1'b0 ||
        ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got key=%h rnd=%0d v=%b b=%b d=%b want all zero",
               ifa.round_key, ifa.round_num, ifa.key_valid, ifa.busy, ifa.done);
    end
    tick();
    n_checks++;
    if (ifa.key_valid !== 1'b0 || ifa.busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_no_resume: got v=%b b=%b want 0 0", ifa.key_valid, ifa.busy);
    end
    run_seq(FipsR10, 1'b0, 1'b0);
    n_checks++;
    if (done_at !== 12 || got_n !== 11) begin
      n_fail++; $display("FAIL rst_mid_rerun: got done_at=%0d keys=%0d want 12, 11", done_at, got_n);
    end
    for (int i = 0; i < 11; i++) begin
      n_checks++;
      if (got_key[i] !== exp_keys[10-i] || got_rnd[i] !== 10 - i) begin
        n_fail++;
        $display("FAIL rst_mid_key[%0d]: got rnd=%0d %h want %h", i, got_rnd[i], got_key[i],
                 exp_keys[10-i]);
      end
    end
  endtask

  task automatic test_scoreboard();
    logic [127:0] key0;
    int           bad, first_bad;
    for (int k = 0; k < 202; k++) begin
      if (k == 0)      key0 = '0;
      else if (k == 1) key0 = '1;
      else             key0 = {$urandom, $urandom, $urandom, $urandom};
      expand(key0);
      run_seq(exp_keys[10], 1'b0, 1'b0);
      bad = (got_n != 11 || done_at < 0) ? 1 : 0;
      first_bad = -1;
      for (int i = 0; i < 11; i++)
        if (got_key[i] !== exp_keys[10-i] || got_rnd[i] !== 10 - i) begin
          bad++;
          if (first_bad < 0) first_bad = i;
        end
      n_checks++;
      if (bad !== 0) begin
        n_fail++;
        $display("FAIL sb_key%0d: key0=%h keys=%0d first bad idx=%0d want 11 matching keys",
                 k, key0, got_n, first_bad);
      end
    end
  endtask

  task automatic test_last_round_1();
    ifb.last_key = FipsR1; ifb.start = 1'b1; ifb.key_ready = 1'b1;
    tick();
    ifb.start = 1'b0;
    n_checks++;
    if (ifb.key_valid !== 1'b1 || ifb.round_num !== 4'd1 || ifb.round_key !== FipsR1) begin
      n_fail++;
      $display("FAIL lr1_round1: got v=%b rnd=%0d %h want 1 1 %h",
               ifb.key_valid, ifb.round_num, ifb.round_key, FipsR1);
    end
    tick();
    n_checks++;
    if (ifb.key_valid !== 1'b1 || ifb.round_num !== 4'd0 || ifb.round_key !== FipsR0) begin
      n_fail++;
      $display("FAIL lr1_round0: got v=%b rnd=%0d %h want 1 0 %h",
               ifb.key_valid, ifb.round_num, ifb.round_key, FipsR0);
    end
    tick();
    n_checks++;
    if (ifb.done !== 1'b1 || ifb.key_valid !== 1'b0 || ifb.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL lr1_done: got d=%b v=%b b=%b want 1 0 0", ifb.done, ifb.key_valid, ifb.busy);
    end
    ifb.key_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    ifa.start = 1'b0; ifa.last_key = '0; ifa.key_ready = 1'b0;
    ifb.start = 1'b0; ifb.last_key = '0; ifb.key_ready = 1'b0;
    build_sbox();
    #1;
    test_reset();
    test_fips();
    test_backpressure();
    test_ignored_start();
    test_reset_mid();
    test_scoreboard();
    test_last_round_1();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
